// File: rtl/nes_controller_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// nes_controller_reader : polls one NES controller and presents its buttons.
// Optional feature macro: NES_DATA_SYNC_EN (2-flop synchronizer on nes_data).
// Revision: 1.0
// ============================================================================
module nes_controller_reader #(
  parameter int HALF_CYCLES = 300,
  parameter int POLL_CYCLES = 833334
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_clock,
  output logic [7:0] buttons,
  output logic       buttons_valid,
  output logic       buttons_changed,
  output logic       busy
);

  localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int HW = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYCLES - 1);
  localparam logic [HW-1:0] PHASE_LAST = HW'(HALF_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_READ  = 3'd2,
    S_PULSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state;
  logic [PW-1:0] poll_cnt;
  logic [HW-1:0] phase_cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          poll_req;
  logic          phase_end;
  logic          data_s;

`ifdef NES_DATA_SYNC_EN
  // Resets to 1 so an idle (pulled-up) line never reads as pressed.
  logic [1:0] sync;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], nes_data};
  end
  assign data_s = sync[1];
`else
  assign data_s = nes_data;
`endif

  assign poll_req  = (poll_cnt == POLL_LAST);
  assign phase_end = (phase_cnt == PHASE_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         poll_cnt <= '0;
    else if (poll_req) poll_cnt <= '0;
    else               poll_cnt <= poll_cnt + 1'b1;
  end

  // idx doubles as the half counter while in LATCH (two phases).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      phase_cnt       <= '0;
      idx             <= '0;
      shift           <= '0;
      nes_latch       <= 1'b0;
      nes_clock       <= 1'b1;
      buttons         <= 8'h00;
      buttons_valid   <= 1'b0;
      buttons_changed <= 1'b0;
      busy            <= 1'b0;
    end else begin
      buttons_valid   <= 1'b0;
      buttons_changed <= 1'b0;
      case (state)
        S_IDLE: begin
          phase_cnt <= '0;
          if (poll_req) begin
            state     <= S_LATCH;
            idx       <= 3'd0;
            nes_latch <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_LATCH: begin
          if (phase_end) begin
            phase_cnt <= '0;
            if (idx == 3'd1) begin
              state     <= S_READ;
              idx       <= 3'd0;
              nes_latch <= 1'b0;
            end else begin
              idx <= 3'd1;
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        S_READ: begin
          if (phase_end) begin
            phase_cnt  <= '0;
            shift[idx] <= data_s;
            if (idx == 3'd7) begin
              state <= S_DONE;
            end else begin
              state     <= S_PULSE;
              nes_clock <= 1'b0;
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        S_PULSE: begin
          if (phase_end) begin
            phase_cnt <= '0;
            idx       <= idx + 3'd1;
            state     <= S_READ;
            nes_clock <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        S_DONE: begin
          buttons         <= ~shift;
          buttons_valid   <= 1'b1;
          buttons_changed <= (~shift != buttons);
          state           <= S_IDLE;
          busy            <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          phase_cnt <= '0;
          nes_latch <= 1'b0;
          nes_clock <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
